// File: rtl/read_sampler_if.sv
// Bus bundle between the DAC/ADC front end and read_sampler.
// rd_min/rd_max exist only when READ_MINMAX_EN is defined.
interface read_sampler_if;
  logic [7:0] pulse;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic [7:0] rd_avg;
  logic       rd_bit;
  logic       rd_valid;
  logic [1:0] rd_index;
  logic       rd_err;
  logic       seq_done;
`ifdef READ_MINMAX_EN
  logic [7:0] rd_min;
  logic [7:0] rd_max;

  modport master (
    output pulse, adc_data, adc_valid,
    input  rd_avg, rd_bit, rd_valid, rd_index, rd_err, seq_done, rd_min, rd_max
  );
  modport slave (
    input  pulse, adc_data, adc_valid,
    output rd_avg, rd_bit, rd_valid, rd_index, rd_err, seq_done, rd_min, rd_max
  );
`else
  modport master (
    output pulse, adc_data, adc_valid,
    input  rd_avg, rd_bit, rd_valid, rd_index, rd_err, seq_done
  );
  modport slave (
    input  pulse, adc_data, adc_valid,
    output rd_avg, rd_bit, rd_valid, rd_index, rd_err, seq_done
  );
`endif
endinterface

// File: rtl/read_sampler.sv
// Detects read windows on the DAC code, settles, averages 2^AVG_LOG2 ADC samples and tags the result.
// Define READ_MINMAX_EN to also report the min/max sample of each window on rd_min/rd_max.
module read_sampler #(
  parameter logic [7:0] READ_CODE = 8'd153,
  parameter int         SETTLE    = 5000,
  parameter int         AVG_LOG2  = 4,
  parameter logic [7:0] THRESH    = 8'd100,
  parameter int         SEQ_READS = 4
) (
  input logic           clk,
  input logic           reset,
  read_sampler_if.slave bus
);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [1:0]       LAST_INDEX  = 2'(SEQ_READS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACQ, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pulse_q, pulse_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       seq_idx_q, seq_idx_d;
  logic [7:0]       rd_avg_q, rd_avg_d;
  logic             rd_bit_q, rd_bit_d;
  logic             rd_valid_q, rd_valid_d;
  logic [1:0]       rd_index_q, rd_index_d;
  logic             rd_err_q, rd_err_d;
  logic             seq_done_q, seq_done_d;
  logic             in_read;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       avg_now;
`ifdef READ_MINMAX_EN
  logic [7:0]       min_acc_q, min_acc_d;
  logic [7:0]       max_acc_q, max_acc_d;
  logic [7:0]       rd_min_q, rd_min_d;
  logic [7:0]       rd_max_q, rd_max_d;
  logic [7:0]       smp_min, smp_max;
`endif

  // The final sample is folded in combinationally so the result strobes on the cycle right after it.
  always_comb begin
    state_d      = state_q;
    pulse_d      = bus.pulse;
    settle_cnt_d = settle_cnt_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    seq_idx_d    = seq_idx_q;
    rd_avg_d     = rd_avg_q;
    rd_bit_d     = rd_bit_q;
    rd_index_d   = rd_index_q;
    rd_valid_d   = 1'b0;
    rd_err_d     = 1'b0;
    seq_done_d   = 1'b0;
    in_read      = (pulse_q == READ_CODE);
    acc_sum      = acc_q + ACC_W'(bus.adc_data);
    avg_now      = acc_sum[AVG_LOG2 +: 8];
`ifdef READ_MINMAX_EN
    min_acc_d    = min_acc_q;
    max_acc_d    = max_acc_q;
    rd_min_d     = rd_min_q;
    rd_max_d     = rd_max_q;
    smp_min      = (bus.adc_data < min_acc_q) ? bus.adc_data : min_acc_q;
    smp_max      = (bus.adc_data > max_acc_q) ? bus.adc_data : max_acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_read) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end
      end

      S_SETTLE: begin
        if (!in_read) begin
          rd_err_d = 1'b1;
          state_d  = S_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_ACQ;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef READ_MINMAX_EN
          min_acc_d = 8'hFF;
          max_acc_d = 8'h00;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      S_ACQ: begin
        // A strobe coinciding with the window end is dropped along with the partial sum.
        if (!in_read) begin
          rd_err_d = 1'b1;
          state_d  = S_IDLE;
        end else if (bus.adc_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
`ifdef READ_MINMAX_EN
          min_acc_d = smp_min;
          max_acc_d = smp_max;
`endif
          if (cnt_q == LAST_SAMPLE) begin
            rd_avg_d   = avg_now;
            rd_bit_d   = (avg_now >= THRESH);
            rd_valid_d = 1'b1;
            rd_index_d = seq_idx_q;
            seq_done_d = (seq_idx_q == LAST_INDEX);
            seq_idx_d  = (seq_idx_q == LAST_INDEX) ? 2'd0 : seq_idx_q + 2'd1;
            state_d    = S_HOLD;
`ifdef READ_MINMAX_EN
            rd_min_d = smp_min;
            rd_max_d = smp_max;
`endif
          end
        end
      end

      S_HOLD: begin
        if (!in_read) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pulse_q      <= '0;
      settle_cnt_q <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      seq_idx_q    <= '0;
      rd_avg_q     <= '0;
      rd_bit_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_index_q   <= '0;
      rd_err_q     <= 1'b0;
      seq_done_q   <= 1'b0;
`ifdef READ_MINMAX_EN
      min_acc_q    <= 8'hFF;
      max_acc_q    <= 8'h00;
      rd_min_q     <= 8'hFF;
      rd_max_q     <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      settle_cnt_q <= settle_cnt_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      seq_idx_q    <= seq_idx_d;
      rd_avg_q     <= rd_avg_d;
      rd_bit_q     <= rd_bit_d;
      rd_valid_q   <= rd_valid_d;
      rd_index_q   <= rd_index_d;
      rd_err_q     <= rd_err_d;
      seq_done_q   <= seq_done_d;
`ifdef READ_MINMAX_EN
      min_acc_q    <= min_acc_d;
      max_acc_q    <= max_acc_d;
      rd_min_q     <= rd_min_d;
      rd_max_q     <= rd_max_d;
`endif
    end
  end

  assign bus.rd_avg   = rd_avg_q;
  assign bus.rd_bit   = rd_bit_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_index = rd_index_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.seq_done = seq_done_q;
`ifdef READ_MINMAX_EN
  assign bus.rd_min   = rd_min_q;
  assign bus.rd_max   = rd_max_q;
`endif

endmodule

// File: tb/tb_read_sampler.sv
// Testbench for read_sampler: directed scenarios plus randomized windows against a window-level model.
// SETTLE is shortened so the whole run stays a few thousand cycles.
module tb_read_sampler;
  localparam int         TB_SETTLE = 40;
  localparam int         NS        = 16;
  localparam int         TB_THRESH = 100;
  localparam logic [7:0] RC        = 8'd153;

  typedef struct {
    logic [7:0] avg;
    logic       dec;
    logic [1:0] idx;
    logic       done;
    logic [7:0] mn;
    logic [7:0] mx;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  read_sampler_if sif();

  read_sampler #(
    .READ_CODE(RC), .SETTLE(TB_SETTLE), .AVG_LOG2(4), .THRESH(8'd100), .SEQ_READS(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(sif)
  );

  always #10 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  res_t       got_q[$];
  res_t       exp_q[$];
  int         got_err, exp_err, stray_done;
  int         model_idx;
  logic [7:0] pat_q[$];
  res_t       mon_r;

  // Collect every result strobe mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (sif.rd_valid === 1'b1) begin
      mon_r.avg  = sif.rd_avg;
      mon_r.dec  = sif.rd_bit;
      mon_r.idx  = sif.rd_index;
      mon_r.done = sif.seq_done;
`ifdef READ_MINMAX_EN
      mon_r.mn   = sif.rd_min;
      mon_r.mx   = sif.rd_max;
`else
      mon_r.mn   = 8'h00;
      mon_r.mx   = 8'h00;
`endif
      got_q.push_back(mon_r);
    end
    if (sif.rd_err === 1'b1) got_err++;
    if (sif.seq_done === 1'b1 && sif.rd_valid !== 1'b1) stray_done++;
  end

  task automatic tick(input logic [7:0] p, input logic v, input logic [7:0] d);
    sif.pulse     = p;
    sif.adc_valid = v;
    sif.adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    got_q.delete();
    exp_q.delete();
    got_err    = 0;
    exp_err    = 0;
    stray_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(8'd0, 1'b0, 8'd0);
    reset = 1'b0;
    tick(8'd0, 1'b0, 8'd0);
    model_idx = 0;
    clear_board();
  endtask

  // Drives one window then a gap; samples well inside the acquisition span come from pat_q (else random).
  // The model: a read window with at least NS such samples yields floor(mean of the first NS), else one error.
  task automatic run_window(input logic [7:0] code, input int len, input int gap, input logic [7:0] gap_code,
                            input int period, input int max_samp, input bit noise);
    logic [7:0] acc[$];
    logic [7:0] d;
    logic       v;
    int         n, next_s, sum;
    res_t       r;
    n      = 0;
    next_s = TB_SETTLE + 6;
    for (int i = 0; i < len; i++) begin
      v = 1'b0;
      d = 8'($urandom);
      if (i == next_s && i <= len - 5 && n < max_samp) begin
        v = 1'b1;
        if (pat_q.size() > 0) d = pat_q.pop_front();
        acc.push_back(d);
        n++;
        next_s = i + period;
      end else if (noise && i <= TB_SETTLE - 4 && $urandom_range(3) == 0) begin
        v = 1'b1;
      end
      tick(code, v, d);
    end
    for (int j = 0; j < gap; j++) begin
      v = noise && j >= 5 && ($urandom_range(3) == 0);
      tick(gap_code, v, 8'($urandom));
    end
    pat_q.delete();
    if (code == RC) begin
      if (acc.size() >= NS) begin
        sum  = 0;
        r.mn = 8'hFF;
        r.mx = 8'h00;
        for (int k = 0; k < NS; k++) begin
          sum += int'(acc[k]);
          if (acc[k] < r.mn) r.mn = acc[k];
          if (acc[k] > r.mx) r.mx = acc[k];
        end
        r.avg     = 8'(sum / NS);
        r.dec     = (sum / NS) >= TB_THRESH;
        r.idx     = 2'(model_idx);
        r.done    = (model_idx == 3);
        model_idx = (model_idx + 1) % 4;
        exp_q.push_back(r);
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(8'd0, 1'b0, 8'd0);
    tick(8'd0, 1'b0, 8'd0);
    checks++; if ({sif.rd_avg, sif.rd_bit, sif.rd_valid, sif.rd_index, sif.rd_err, sif.seq_done} !== 14'd0) begin errors++; $display("[TB] FAIL reset outputs: got avg=%0d bit=%0b valid=%0b idx=%0d err=%0b done=%0b expected all 0", sif.rd_avg, sif.rd_bit, sif.rd_valid, sif.rd_index, sif.rd_err, sif.seq_done); end
`ifdef READ_MINMAX_EN
    checks++; if ({sif.rd_min, sif.rd_max} !== 16'hFF00) begin errors++; $display("[TB] FAIL reset minmax: got min=%0h max=%0h expected ff/00", sif.rd_min, sif.rd_max); end
`endif
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(8'd0, 1'b1, 8'd200);
    checks++; if (sif.rd_valid !== 1'b0 || sif.rd_err !== 1'b0) begin errors++; $display("[TB] FAIL idle strobes: got valid=%0b err=%0b expected 0/0", sif.rd_valid, sif.rd_err); end
    model_idx = 0;
    clear_board();
  endtask

  task automatic test_window_integrity();
    clear_board();
    for (int i = 0; i < 40; i++) pat_q.push_back(8'd120);
    run_window(RC, 1200, 20, 8'd0, 50, 1000, 1'b0);
    checks++; if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL integrity count: got %0d expected 1", got_q.size()); end
    checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL integrity err: got %0d expected 0", got_err); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0].avg !== 8'd120) begin errors++; $display("[TB] FAIL integrity avg: got %0d expected 120", got_q[0].avg); end
      checks++; if (got_q[0].dec !== 1'b1) begin errors++; $display("[TB] FAIL integrity bit: got %0b expected 1", got_q[0].dec); end
      checks++; if (got_q[0].idx !== 2'd0) begin errors++; $display("[TB] FAIL integrity idx: got %0d expected 0", got_q[0].idx); end
    end
  endtask

  task automatic test_average_threshold();
    clear_board();
    for (int i = 0; i < NS; i++) pat_q.push_back((i % 2 == 0) ? 8'd99 : 8'd100);
    run_window(RC, 120, 20, 8'd128, 4, NS, 1'b1);
    for (int i = 0; i < NS; i++) pat_q.push_back(8'd100);
    run_window(RC, 120, 20, 8'd0, 4, NS, 1'b1);
    checks++; if (got_q.size() !== 2) begin errors++; $display("[TB] FAIL avg count: got %0d expected 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      checks++; if ({got_q[0].avg, got_q[0].dec} !== {8'd99, 1'b0}) begin errors++; $display("[TB] FAIL avg 99/100: got avg=%0d bit=%0b expected 99/0", got_q[0].avg, got_q[0].dec); end
      checks++; if ({got_q[1].avg, got_q[1].dec} !== {8'd100, 1'b1}) begin errors++; $display("[TB] FAIL thresh boundary: got avg=%0d bit=%0b expected 100/1", got_q[1].avg, got_q[1].dec); end
      checks++; if ({got_q[0].idx, got_q[1].idx} !== {2'd1, 2'd2}) begin errors++; $display("[TB] FAIL avg idx: got %0d,%0d expected 1,2", got_q[0].idx, got_q[1].idx); end
    end
  endtask

  task automatic test_ignored_windows();
    logic [7:0] codes [3];
    codes = '{8'd191, 8'd128, 8'd0};
    clear_board();
    for (int c = 0; c < 3; c++) run_window(codes[c], 600, 20, 8'd128, 10, 100, 1'b1);
    checks++; if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL ignored valid: got %0d expected 0", got_q.size()); end
    checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL ignored err: got %0d expected 0", got_err); end
  endtask

  task automatic test_early_end();
    do_reset();
    run_window(RC, 25, 20, 8'd0, 3, 0, 1'b1);
    checks++; if (got_err !== 1) begin errors++; $display("[TB] FAIL early settle err: got %0d expected 1", got_err); end
    run_window(RC, 75, 20, 8'd128, 3, 8, 1'b1);
    checks++; if (got_err !== 2 || got_q.size() !== 0) begin errors++; $display("[TB] FAIL early acq: got err=%0d valid=%0d expected 2/0", got_err, got_q.size()); end
    run_window(RC, 120, 20, 8'd0, 4, NS, 1'b1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("[TB] FAIL early recover count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (got_q[0].idx !== 2'd0) begin errors++; $display("[TB] FAIL early recover idx: got %0d expected 0", got_q[0].idx); end
      checks++; if (got_q[0].avg !== exp_q[0].avg) begin errors++; $display("[TB] FAIL early recover avg: got %0d expected %0d", got_q[0].avg, exp_q[0].avg); end
    end
    checks++; if (got_err !== exp_err) begin errors++; $display("[TB] FAIL early err total: got %0d expected %0d", got_err, exp_err); end
  endtask

  task automatic test_sequence_wrap();
    do_reset();
    for (int w = 0; w < 5; w++) run_window(RC, 120, 300, 8'd128, 4, NS, 1'b1);
    checks++; if (got_q.size() !== 5) begin errors++; $display("[TB] FAIL wrap count: got %0d expected 5", got_q.size()); end
    for (int k = 0; k < 5 && k < got_q.size() && k < exp_q.size(); k++) begin
      checks++; if ({got_q[k].idx, got_q[k].done} !== {2'(k % 4), (k == 3)}) begin errors++; $display("[TB] FAIL wrap read %0d: got idx=%0d done=%0b expected idx=%0d done=%0b", k, got_q[k].idx, got_q[k].done, k % 4, k == 3); end
      checks++; if (got_q[k].avg !== exp_q[k].avg) begin errors++; $display("[TB] FAIL wrap avg %0d: got %0d expected %0d", k, got_q[k].avg, exp_q[k].avg); end
    end
    checks++; if (stray_done !== 0 || got_err !== 0) begin errors++; $display("[TB] FAIL wrap strays: got done=%0d err=%0d expected 0/0", stray_done, got_err); end
  endtask

  task automatic test_reset_mid_acq();
    clear_board();
    for (int i = 0; i < NS; i++) pat_q.push_back(8'd200);
    run_window(RC, 120, 20, 8'd0, 4, NS, 1'b0);
    checks++; if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0].avg !== 8'd200)) begin errors++; $display("[TB] FAIL pre-reset read: got count=%0d expected one read of 200", got_q.size()); end
    for (int i = 0; i < 70; i++) tick(RC, (i >= TB_SETTLE + 6 && (i - TB_SETTLE - 6) % 3 == 0 && i <= TB_SETTLE + 27), 8'd50);
    reset = 1'b1;
    tick(8'd0, 1'b0, 8'd0);
    checks++; if ({sif.rd_avg, sif.rd_bit, sif.rd_valid, sif.rd_index, sif.rd_err, sif.seq_done} !== 14'd0) begin errors++; $display("[TB] FAIL mid-acq reset: got avg=%0d bit=%0b valid=%0b idx=%0d err=%0b done=%0b expected all 0", sif.rd_avg, sif.rd_bit, sif.rd_valid, sif.rd_index, sif.rd_err, sif.seq_done); end
    reset = 1'b0;
    model_idx = 0;
    clear_board();
    tick(8'd0, 1'b0, 8'd0);
    for (int i = 10; i <= 25; i++) pat_q.push_back(8'(i));
    run_window(RC, 120, 20, 8'd0, 4, NS, 1'b1);
    checks++; if (got_q.size() !== 1 || got_err !== 0) begin errors++; $display("[TB] FAIL post-reset read: got count=%0d err=%0d expected 1/0", got_q.size(), got_err); end
    if (got_q.size() > 0) begin
      checks++; if ({got_q[0].avg, got_q[0].dec, got_q[0].idx} !== {8'd17, 1'b0, 2'd0}) begin errors++; $display("[TB] FAIL post-reset result: got avg=%0d bit=%0b idx=%0d expected 17/0/0", got_q[0].avg, got_q[0].dec, got_q[0].idx); end
`ifdef READ_MINMAX_EN
      checks++; if ({got_q[0].mn, got_q[0].mx} !== {8'd10, 8'd25}) begin errors++; $display("[TB] FAIL post-reset minmax: got %0d/%0d expected 10/25", got_q[0].mn, got_q[0].mx); end
`endif
    end
  endtask

  task automatic test_random_windows();
    logic [7:0] code, gcode;
    int         len;
    do_reset();
    for (int w = 0; w < 14; w++) begin
      case ($urandom_range(9))
        6:       code = 8'd191;
        7:       code = 8'd128;
        8:       code = 8'd0;
        9:       code = 8'($urandom);
        default: code = RC;
      endcase
      if ($urandom_range(9) == 9 && code == RC) code = 8'd154;
      len = ($urandom_range(3) == 0) ? $urandom_range(TB_SETTLE - 4, 8) : $urandom_range(260, TB_SETTLE + 12);
      case ($urandom_range(2))
        0:       gcode = 8'd0;
        1:       gcode = 8'd128;
        default: gcode = 8'd191;
      endcase
      run_window(code, len, $urandom_range(40, 6), gcode, $urandom_range(8, 1), $urandom_range(20, 10), 1'b1);
    end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL random count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_err !== exp_err) begin errors++; $display("[TB] FAIL random err: got %0d expected %0d", got_err, exp_err); end
    checks++; if (stray_done !== 0) begin errors++; $display("[TB] FAIL random stray done: got %0d expected 0", stray_done); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if ({got_q[k].avg, got_q[k].dec, got_q[k].idx, got_q[k].done} !== {exp_q[k].avg, exp_q[k].dec, exp_q[k].idx, exp_q[k].done}) begin errors++; $display("[TB] FAIL random read %0d: got avg=%0d bit=%0b idx=%0d done=%0b expected avg=%0d bit=%0b idx=%0d done=%0b", k, got_q[k].avg, got_q[k].dec, got_q[k].idx, got_q[k].done, exp_q[k].avg, exp_q[k].dec, exp_q[k].idx, exp_q[k].done); end
`ifdef READ_MINMAX_EN
      checks++; if ({got_q[k].mn, got_q[k].mx} !== {exp_q[k].mn, exp_q[k].mx}) begin errors++; $display("[TB] FAIL random minmax %0d: got %0d/%0d expected %0d/%0d", k, got_q[k].mn, got_q[k].mx, exp_q[k].mn, exp_q[k].mx); end
`endif
    end
  endtask

  // Scenarios run back to back; later ones rely on the sequence index left by earlier ones or reset it.
  initial begin
    reset         = 1'b1;
    sif.pulse     = 8'd0;
    sif.adc_valid = 1'b0;
    sif.adc_data  = 8'd0;
    model_idx     = 0;
    clear_board();
    @(posedge clk);
    #1;
    test_reset();
    test_window_integrity();
    test_average_threshold();
    test_ignored_windows();
    test_early_end();
    test_sequence_wrap();
    test_reset_mid_acq();
    test_random_windows();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
